// File: rtl/pipelined_multiplier_pkg.sv
// Shared constants for the shift-add pipelined multiplier.
// Holds the default operand width and the end-to-end latency helper, so RTL
// and bench agree on how many register stages a product passes through.
package pipelined_multiplier_pkg;

  // Default operand width and its legal range.
  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  // Register stages from operand capture to product: input register,
  // one adder stage per multiplier bit, then the output register.
  function automatic int latency(input int width);
    return width + 2;
  endfunction

  localparam int LATENCY = latency(DEFAULT_WIDTH);

endpackage

// File: rtl/pipelined_multiplier_if.sv
// Operand/result bus of the pipelined multiplier.
// The producer side (master) drives start/a/b and samples product on valid;
// the multiplier (slave) consumes operands and drives the result.
interface pipelined_multiplier_if
  import pipelined_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] product;
  logic               valid;

  modport master (
    output start,
    output a,
    output b,
    input  product,
    input  valid
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output product,
    output valid
  );

endinterface

// File: rtl/pipelined_multiplier_stage.sv
// One adder stage of the shift-add multiplier.
// Stage STAGE (1..WIDTH) adds the partial product for multiplier bit STAGE-1
// to the running accumulator and forwards operands, sum and valid tag one
// register further down the chain.
module pipelined_multiplier_stage
  import pipelined_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STAGE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2*WIDTH-1:0] in_acc,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [2*WIDTH-1:0] out_acc
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;

  logic               valid_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc_reg;

  // Partial product for this stage's multiplier bit; the 2*WIDTH-bit sum
  // cannot overflow because the full product fits in 2*WIDTH bits.
  always_comb begin
    a_ext    = {{WIDTH{1'b0}}, in_a};
    partial  = in_b[STAGE-1] ? (a_ext << (STAGE - 1)) : '0;
    acc_next = in_acc + partial;
  end

  // Stage register: forward operands, updated sum and valid tag every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
    end else begin
      valid_reg <= in_valid;
      a_reg     <= in_a;
      b_reg     <= in_b;
      acc_reg   <= acc_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_a     = a_reg;
  assign out_b     = b_reg;
  assign out_acc   = acc_reg;

endmodule

// File: rtl/pipelined_multiplier.sv
// Unsigned WIDTH x WIDTH shift-add pipelined multiplier.
// Input register -> WIDTH adder stages -> output register; one operand pair
// accepted per cycle on start, product returned with a one-cycle valid pulse
// latency(WIDTH) register stages later. No backpressure.
// Build option: define PIPELINED_MULTIPLIER_PROD_HOLD_EN to keep product at
// the last result between valid pulses; otherwise product reads 0 whenever
// valid is low.
module pipelined_multiplier
  import pipelined_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  pipelined_multiplier_if.slave bus
);

  // Reject widths the partial-product indexing and 2*WIDTH sum do not cover.
  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("pipelined_multiplier: WIDTH out of range");
    end
  endgenerate

  // Input register.
  logic               in_valid_reg;
  logic [WIDTH-1:0]   in_a_reg;
  logic [WIDTH-1:0]   in_b_reg;

  // Chain between stages; index 0 is the input register, index WIDTH the
  // last adder stage.
  logic               valid_chain [0:WIDTH];
  logic [WIDTH-1:0]   a_chain     [0:WIDTH];
  logic [WIDTH-1:0]   b_chain     [0:WIDTH];
  logic [2*WIDTH-1:0] acc_chain   [0:WIDTH];

  // Output register.
  logic               valid_reg;
  logic [2*WIDTH-1:0] product_reg;

  // Capture operands on start; operands are held while idle so the data
  // path only toggles when a new pair arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_valid_reg <= 1'b0;
      in_a_reg     <= '0;
      in_b_reg     <= '0;
    end else begin
      in_valid_reg <= bus.start;
      if (bus.start) begin
        in_a_reg <= bus.a;
        in_b_reg <= bus.b;
      end
    end
  end

  // A freshly accepted pair always enters the adder chain with a zero sum.
  assign valid_chain[0] = in_valid_reg;
  assign a_chain[0]     = in_a_reg;
  assign b_chain[0]     = in_b_reg;
  assign acc_chain[0]   = '0;

  genvar gi;
  generate
    for (gi = 1; gi <= WIDTH; gi++) begin : g_stage
      pipelined_multiplier_stage #(
        .WIDTH (WIDTH),
        .STAGE (gi)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (valid_chain[gi-1]),
        .in_a      (a_chain[gi-1]),
        .in_b      (b_chain[gi-1]),
        .in_acc    (acc_chain[gi-1]),
        .out_valid (valid_chain[gi]),
        .out_a     (a_chain[gi]),
        .out_b     (b_chain[gi]),
        .out_acc   (acc_chain[gi])
      );
    end
  endgenerate

  // Output register: present a finished product with a one-cycle valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg   <= 1'b0;
      product_reg <= '0;
    end else begin
      valid_reg <= valid_chain[WIDTH];
`ifdef PIPELINED_MULTIPLIER_PROD_HOLD_EN
      if (valid_chain[WIDTH]) begin
        product_reg <= acc_chain[WIDTH];
      end
`else
      product_reg <= valid_chain[WIDTH] ? acc_chain[WIDTH] : '0;
`endif
    end
  end

  assign bus.valid   = valid_reg;
  assign bus.product = product_reg;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed bench for pipelined_multiplier at the default width.
// Expected products and timing are hand-computed constants; the valid pulse
// is expected latency(W)-1 edges after the accepting edge.
module tb_pipelined_multiplier;
  import pipelined_multiplier_pkg::*;

  localparam int W   = DEFAULT_WIDTH;
  localparam int LAT = latency(W);

  logic clk;
  logic reset;

  int total;
  int bad;

  pipelined_multiplier_if #(.WIDTH(W)) bus ();

  pipelined_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One isolated operation; entered and left just after a rising edge.
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input logic [2*W-1:0] exp_after);
    int first;
    int pulses;
    logic [2*W-1:0] got;
    logic [2*W-1:0] after;
    first  = -1;
    pulses = 0;
    got    = '0;
    after  = '0;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    // Operands change after acceptance; must not disturb the result.
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        pulses++;
        if (first < 0) begin
          first = k;
          got   = bus.product;
        end
      end
      if (first >= 0 && k == first + 1) after = bus.product;
    end
    $display("txn a=%0d b=%0d product=%0d edge=%0d pulses=%0d next=%0d",
             a, b, got, first, pulses, after);
    check("single_lat",    64'(first),  64'(LAT - 1));
    check("single_pulses", 64'(pulses), 64'd1);
    check("single_prod",   64'(got),    64'(exp));
    check("single_after",  64'(after),  64'(exp_after));
  endtask

  initial begin
    int cnt;
    logic [2*W-1:0] prod_or;
    int ks [0:3];
    logic [2*W-1:0] ps [0:3];

    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state.
    #1;
    check("reset_valid",   64'(bus.valid),   64'd0);
    check("reset_product", 64'(bus.product), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Idle: no start for 50 cycles.
    cnt = 0;
    prod_or = '0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.valid) cnt++;
      prod_or |= bus.product;
    end
    $display("txn idle cycles=50 pulses=%0d product_or=%0d", cnt, prod_or);
    check("idle_pulses",  64'(cnt),     64'd0);
    check("idle_product", 64'(prod_or), 64'd0);

    // Single operations; value one cycle after the pulse depends on build.
`ifdef PIPELINED_MULTIPLIER_PROD_HOLD_EN
    run_single(8'd5,   8'd3,   16'd15,    16'd15);
    run_single(8'd15,  8'd15,  16'd225,   16'd225);
    run_single(8'd128, 8'd2,   16'd256,   16'd256);
    run_single(8'd0,   8'd200, 16'd0,     16'd0);
    run_single(8'd255, 8'd255, 16'd65025, 16'd65025);
    run_single(8'd7,   8'd9,   16'd63,    16'd63);
`else
    run_single(8'd5,   8'd3,   16'd15,    16'd0);
    run_single(8'd15,  8'd15,  16'd225,   16'd0);
    run_single(8'd128, 8'd2,   16'd256,   16'd0);
    run_single(8'd0,   8'd200, 16'd0,     16'd0);
    run_single(8'd255, 8'd255, 16'd65025, 16'd0);
    run_single(8'd7,   8'd9,   16'd63,    16'd0);
`endif

    // Back-to-back: three accepted pairs on consecutive edges (k = 0,1,2).
    bus.start = 1'b1;
    bus.a = 8'd1;   bus.b = 8'd1;
    @(posedge clk); #1;
    bus.a = 8'd2;   bus.b = 8'd3;
    @(posedge clk); #1;
    bus.a = 8'd255; bus.b = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      ks[i] = -1;
      ps[i] = '0;
    end
    for (int k = 3; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        if (cnt < 4) begin
          ks[cnt] = k;
          ps[cnt] = bus.product;
        end
        cnt++;
      end
    end
    $display("txn b2b pulses=%0d edges=%0d,%0d,%0d products=%0d,%0d,%0d",
             cnt, ks[0], ks[1], ks[2], ps[0], ps[1], ps[2]);
    check("b2b_pulses", 64'(cnt),   64'd3);
    check("b2b_edge0",  64'(ks[0]), 64'(LAT - 1));
    check("b2b_edge1",  64'(ks[1]), 64'(LAT));
    check("b2b_edge2",  64'(ks[2]), 64'(LAT + 1));
    check("b2b_prod0",  64'(ps[0]), 64'd1);
    check("b2b_prod1",  64'(ps[1]), 64'd6);
    check("b2b_prod2",  64'(ps[2]), 64'd255);

    // Reset mid-flight: accept (12,12), assert reset 4 cycles later.
    bus.start = 1'b1;
    bus.a = 8'd12;
    bus.b = 8'd12;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_valid",   64'(bus.valid),   64'd0);
    check("midrst_product", 64'(bus.product), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    prod_or = '0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(posedge clk); #1;
      if (bus.valid) cnt++;
      prod_or |= bus.product;
    end
    $display("txn reset_flush pulses=%0d product_or=%0d", cnt, prod_or);
    check("midrst_pulses", 64'(cnt),     64'd0);
    check("midrst_prod",   64'(prod_or), 64'd0);

    // Pipeline works again after reset.
`ifdef PIPELINED_MULTIPLIER_PROD_HOLD_EN
    run_single(8'd3, 8'd4, 16'd12, 16'd12);
`else
    run_single(8'd3, 8'd4, 16'd12, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Unsigned WIDTH×WIDTH multiplier built as a shift-add pipeline, one partial product per stage. Accepts one operand pair per clock when `start` is high and returns the 2·WIDTH-bit product with a one-cycle `valid` pulse a fixed number of cycles later. It sits between any producer of operand pairs and a consumer that samples `product` on `valid`; there is no backpressure.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2–32.
- `clk` input 1: rising-edge clock; all state is in this domain.
- `reset` input 1: asynchronous, active-low; asserted at 0, released synchronously to `clk`.
- `start` input 1: qualifies `a`/`b`; an operand pair is accepted on every rising edge where `start`=1.
- `a` input WIDTH: unsigned multiplicand.
- `b` input WIDTH: unsigned multiplier.
- `product` output 2·WIDTH: unsigned a×b of the pair whose result is signalled.
- `valid` output 1: high for exactly one cycle per accepted pair, while `product` holds that pair's result.

## Operation
- Stage 0 (input register): on an edge with `start`=1, capture `a`, `b`, clear the accumulator, set the stage valid bit; with `start`=0 the stage valid bit is cleared and the data registers keep their values.
- Stages 1..WIDTH: stage k adds (b[k-1] ? a<<(k-1) : 0) to the accumulator and forwards a, b, accumulator and valid bit; arithmetic is 2·WIDTH bits wide and never overflows (max (2^W−1)^2).
- Output register: when the stage-WIDTH valid bit is set, load `product` from the accumulator and drive `valid`=1; otherwise `valid`=0.
- Fully pipelined: back-to-back `start` pulses yield back-to-back results in input order, throughput one product per cycle.
- Operands are sampled only at the accepting edge; later changes to `a`/`b` do not affect an in-flight result.
- No state machine; the pipeline is a chain of valid-tagged registers.

## Timing
- Latency: `start` sampled high at edge N → `valid`=1 and `product` correct during the cycle after edge N+WIDTH+1 (WIDTH+2 register stages total: input, WIDTH adder stages, output). For WIDTH=8: 10 cycles.
- `valid` is a single-cycle pulse per accepted pair; consecutive accepted pairs produce consecutive pulses.
- Reset (`reset`=0), asynchronous: all valid bits, `valid`, `product` and all data registers go to 0 immediately; in-flight operations are discarded and never produce a `valid` pulse.
- After release, the first `valid` can appear no earlier than WIDTH+2 edges after the first accepted `start`.
- `start` asserted on the same edge reset is released is ignored (the reset is still asserted at that edge).

## Configuration
- Macro `PIPELINED_MULTIPLIER_PROD_HOLD_EN`.
- Defined: `product` holds the last valid result until the next `valid` pulse or reset.
- Undefined: `product` is driven 0 in every cycle where `valid`=0 (the output register is zeroed whenever the stage-WIDTH valid bit is clear).
- `valid` timing is identical in both builds.

## Structure
- Package `pipelined_multiplier_pkg`: default `WIDTH` constant and a latency constant/function returning WIDTH+2, both used by RTL and bench.
- One sub-module, `pipelined_multiplier_stage`: parameterized by WIDTH and stage index; registers a, b, accumulator and valid bit; instantiated WIDTH times via generate.
- Top level contains the input register, the generate chain and the output register.

## Test plan
- Single operations, WIDTH=8, one at a time: 5×3 → 15; 15×15 → 225; 128×2 → 256; 0×200 → 0; 255×255 → 65025; each with exactly one `valid` pulse, 10 cycles after `start`.
- Back-to-back: `start` high for 3 consecutive cycles with (1,1), (2,3), (255,1) → `valid` high 3 consecutive cycles with 1, 6, 255 in order.
- Operand change after acceptance: accept (7,9), then drive (0,0) with `start`=0 → result 63, no extra `valid`.
- Reset mid-flight: accept (12,12), pull `reset` low 4 cycles later → `valid` and `product` 0 immediately, no pulse for 144 after release.
- Idle: `start` held 0 for 50 cycles after reset → `valid` never asserts; `product` stays 0.
- Build with and without `PIPELINED_MULTIPLIER_PROD_HOLD_EN`: after 5×3, `product` reads 15 (hold) or 0 (no hold) one cycle after the `valid` pulse.
